frame_checker: RTL and testbench

Receive-side counterpart of the frame generator: an AXI-Stream sink that consumes 16-bit Ethernet-style frames (preamble/SFD, destination MAC, source MAC, length, type, payload) and validates preamble and length. It accumulates a payload byte checksum and exposes the last good frame's header, checksum and frame/error statistics over an 8-bit Avalon-MM slave. It sits at the far end of a packet-filter egress stream for loopback self-test of the generator and filter.

---
 rtl/frame_checker_if.sv | 32 +++
 rtl/frame_checker.sv | 234 +++++++++++++++++++++++
 tb/tb_frame_checker.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_checker_if.sv
// frame_checker_if: Avalon-MM register port plus AXI-Stream ingress.
// master = stream source / bus host, slave = frame_checker.
interface frame_checker_if;
   logic [7:0]  writedata;
   logic        write;
   logic        chipselect;
   logic [7:0]  address;
   logic        read;
   logic [7:0]  readdata;
   logic [15:0] ingress_port_tdata;
   logic        ingress_port_tlast;
   logic        ingress_port_tready;
   logic        ingress_port_tvalid;

   modport master (
      output writedata, write, chipselect,
      output address, read,
      output ingress_port_tdata,
      output ingress_port_tlast,
      output ingress_port_tvalid,
      input  readdata, ingress_port_tready
   );

   modport slave (
      input  writedata, write, chipselect,
      input  address, read,
      input  ingress_port_tdata,
      input  ingress_port_tlast,
      input  ingress_port_tvalid,
      output readdata, ingress_port_tready
   );
endinterface

// File: rtl/frame_checker.sv
// frame_checker: stream frame sink with preamble/length checks and
// Avalon-MM stats; FRAME_CHECKER_ERR_COUNT_EN adds the error counter.
module frame_checker #(
   parameter int MAX_PAYLOAD = 1500
) (
   input  logic           clk,
   input  logic           reset,
   frame_checker_if.slave bus
);
   localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
   localparam logic [15:0] PRE_W   = 16'hAAAA;
   localparam logic [15:0] SFD_W   = 16'hAAAB;

   typedef enum logic [2:0] {
      PREAMBLE, HEADER, PAYLOAD, DRAIN, COMMIT
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  k_q, k_d;
   logic [9:0]  rem_q, rem_d;
   logic        tready_q, tready_d;
   logic [47:0] dst_sh_q, dst_sh_d;
   logic [47:0] src_sh_q, src_sh_d;
   logic [15:0] len_sh_q, len_sh_d;
   logic [15:0] type_sh_q, type_sh_d;
   logic [31:0] sum_sh_q, sum_sh_d;
   logic [47:0] dst_q, dst_d;
   logic [47:0] src_q, src_d;
   logic [15:0] len_q, len_d;
   logic [15:0] type_q, type_d;
   logic [31:0] csum_q, csum_d;
   logic [15:0] good_q, good_d;
   logic [1:0]  status_q, status_d;
   logic [7:0]  readdata_q, readdata_d;

   logic        acc, tlast, fin;
   logic        pre_err, len_err, commit;
   logic [15:0] tdata, swap;
   logic        wr_en, rd_en, clr, w1c;
   logic [15:0] err_rd;
   logic [199:0] rmap;
   logic [10:0] ridx;

   assign tdata = bus.ingress_port_tdata;
   assign tlast = bus.ingress_port_tlast;
   // byte 0 of every header field rides in [15:8]
   assign swap  = {tdata[7:0], tdata[15:8]};
   assign acc   = bus.ingress_port_tvalid & tready_q;
   assign fin   = (rem_q == 10'd1);

   assign bus.ingress_port_tready = tready_q;
   assign bus.readdata            = readdata_q;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      rem_d     = rem_q;
      dst_sh_d  = dst_sh_q;
      src_sh_d  = src_sh_q;
      len_sh_d  = len_sh_q;
      type_sh_d = type_sh_q;
      sum_sh_d  = sum_sh_q;
      pre_err   = 1'b0;
      len_err   = 1'b0;
      commit    = 1'b0;
      unique case (state_q)
         PREAMBLE: if (acc) begin
            k_d = k_q + 4'd1;
            if (tdata != ((k_q == 4'd3) ? SFD_W : PRE_W)) begin
               pre_err = 1'b1;
               k_d     = 4'd0;
               state_d = tlast ? PREAMBLE : DRAIN;
            end else if (tlast) begin
               len_err = 1'b1;
               k_d     = 4'd0;
            end else if (k_q == 4'd3) begin
               state_d = HEADER;
            end
         end
         HEADER: if (acc) begin
            k_d = k_q + 4'd1;
            if (k_q <= 4'd6)
               dst_sh_d = {swap, dst_sh_q[47:16]};
            else if (k_q <= 4'd9)
               src_sh_d = {swap, src_sh_q[47:16]};
            else if (k_q == 4'd10)
               len_sh_d = swap;
            else
               type_sh_d = swap;
            if (k_q == 4'd11) begin
               k_d      = 4'd0;
               sum_sh_d = '0;
               rem_d    = len_sh_q[10:1]
                        + {9'd0, len_sh_q[0]};
               if (len_sh_q > MAX_LEN) begin
                  len_err = 1'b1;
                  state_d = tlast ? PREAMBLE : DRAIN;
               end else if (len_sh_q == 16'd0) begin
                  len_err = ~tlast;
                  state_d = tlast ? COMMIT : DRAIN;
               end else if (tlast) begin
                  len_err = 1'b1;
                  state_d = PREAMBLE;
               end else begin
                  state_d = PAYLOAD;
               end
            end else if (tlast) begin
               len_err = 1'b1;
               k_d     = 4'd0;
               state_d = PREAMBLE;
            end
         end
         PAYLOAD: if (acc) begin
            rem_d    = rem_q - 10'd1;
            sum_sh_d = sum_sh_q + {24'd0, tdata[7:0]};
            // odd length: the pad byte of the last beat is ignored
            if (!(fin && len_sh_q[0]))
               sum_sh_d = sum_sh_d + {24'd0, tdata[15:8]};
            if (fin) begin
               len_err = ~tlast;
               state_d = tlast ? COMMIT : DRAIN;
            end else if (tlast) begin
               len_err = 1'b1;
               state_d = PREAMBLE;
            end
         end
         DRAIN: if (acc && tlast) begin
            state_d = PREAMBLE;
         end
         COMMIT: begin
            commit  = 1'b1;
            state_d = PREAMBLE;
         end
         default: state_d = PREAMBLE;
      endcase
      tready_d = (state_d != COMMIT);
   end

   assign wr_en = bus.chipselect & bus.write;
   assign rd_en = bus.chipselect & bus.read;
   assign clr   = wr_en && (bus.address == 8'd25);
   assign w1c   = wr_en && (bus.address == 8'd24);

   always_comb begin
      dst_d    = commit ? dst_sh_q : dst_q;
      src_d    = commit ? src_sh_q : src_q;
      len_d    = commit ? len_sh_q : len_q;
      type_d   = commit ? type_sh_q : type_q;
      csum_d   = commit ? sum_sh_q : csum_q;
      good_d   = good_q;
      if (commit && good_q != 16'hFFFF)
         good_d = good_q + 16'd1;
      if (clr) begin
         csum_d = '0;
         good_d = '0;
      end
      status_d = status_q;
      if (w1c)
         status_d = status_q & ~bus.writedata[1:0];
      status_d = status_d | {len_err, pre_err};
   end

`ifdef FRAME_CHECKER_ERR_COUNT_EN
   logic [15:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (clr)
         err_d = '0;
      else if ((pre_err | len_err) && err_q != 16'hFFFF)
         err_d = err_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) err_q <= '0;
      else        err_q <= err_d;
   end

   assign err_rd = err_q;
`else
   assign err_rd = '0;
`endif

   // byte address a lives at rmap[8a +: 8]
   assign rmap = {6'd0, status_q, err_rd, good_q, csum_q,
                  type_q, len_q, src_q, dst_q};
   assign ridx = {bus.address, 3'b000};

   always_comb begin
      readdata_d = 8'd0;
      if (rd_en && bus.address < 8'd25)
         readdata_d = rmap[ridx +: 8];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= PREAMBLE;
         k_q        <= '0;
         rem_q      <= '0;
         tready_q   <= 1'b0;
         dst_sh_q   <= '0;
         src_sh_q   <= '0;
         len_sh_q   <= '0;
         type_sh_q  <= '0;
         sum_sh_q   <= '0;
         dst_q      <= '0;
         src_q      <= '0;
         len_q      <= '0;
         type_q     <= '0;
         csum_q     <= '0;
         good_q     <= '0;
         status_q   <= '0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         rem_q      <= rem_d;
         tready_q   <= tready_d;
         dst_sh_q   <= dst_sh_d;
         src_sh_q   <= src_sh_d;
         len_sh_q   <= len_sh_d;
         type_sh_q  <= type_sh_d;
         sum_sh_q   <= sum_sh_d;
         dst_q      <= dst_d;
         src_q      <= src_d;
         len_q      <= len_d;
         type_q     <= type_d;
         csum_q     <= csum_d;
         good_q     <= good_d;
         status_q   <= status_d;
         readdata_q <= readdata_d;
      end
   end
endmodule

// File: tb/tb_frame_checker.sv
// tb_frame_checker: directed vectors and register-read table
// for frame_checker, including reset, clear and length corners.
`timescale 1ns/1ps
module tb_frame_checker;
   logic clk = 1'b0;
   logic reset;

   frame_checker_if bus();

   frame_checker dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef FRAME_CHECKER_ERR_COUNT_EN
   localparam int ERR_EN = 1;
`else
   localparam int ERR_EN = 0;
`endif

   typedef struct packed {
      logic [15:0] d;
      logic        l;
   } beat_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] e;
   } rv_t;

   int    checks   = 0;
   int    failures = 0;
   beat_t q[$];
   rv_t   tbl[27];

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  nm, got, exp);
      end
   endtask

   task automatic pushb(input logic [15:0] d, input logic l);
      beat_t t;
      t.d = d;
      t.l = l;
      q.push_back(t);
   endtask

   task automatic hdr(input logic [15:0] len,
                      input logic [15:0] typ);
      q.delete();
      pushb(16'hAAAA, 1'b0);
      pushb(16'hAAAA, 1'b0);
      pushb(16'hAAAA, 1'b0);
      pushb(16'hAAAB, 1'b0);
      pushb(16'h0102, 1'b0);
      pushb(16'h0304, 1'b0);
      pushb(16'h0506, 1'b0);
      pushb(16'h1112, 1'b0);
      pushb(16'h1314, 1'b0);
      pushb(16'h1516, 1'b0);
      pushb({len[7:0], len[15:8]}, 1'b0);
      pushb(typ, 1'b0);
   endtask

   // call at a negedge; returns at the negedge after acceptance
   task automatic send(input logic [15:0] d, input logic l);
      int n = 0;
      while (bus.ingress_port_tready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20)
         chk("tready_timeout", bus.ingress_port_tready, 1);
      bus.ingress_port_tvalid = 1'b1;
      bus.ingress_port_tdata  = d;
      bus.ingress_port_tlast  = l;
      @(negedge clk);
      bus.ingress_port_tvalid = 1'b0;
      bus.ingress_port_tlast  = 1'b0;
   endtask

   task automatic send_q(input int maxgap);
      for (int i = 0; i < q.size(); i++) begin
         send(q[i].d, q[i].l);
         if (maxgap > 0 && i != q.size() - 1)
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
      end
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] v);
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = a;
      @(negedge clk);
      v              = bus.readdata;
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
   endtask

   task automatic chk_rd(input string nm,
                         input logic [7:0] a,
                         input logic [7:0] e);
      logic [7:0] v;
      rd(a, v);
      chk($sformatf("%s@%0d", nm, a), v, e);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus.chipselect = 1'b1;
      bus.write      = 1'b1;
      bus.address    = a;
      bus.writedata  = d;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 6; i++)
         tbl[i] = '{8'(i), 8'(i + 1)};
      for (int i = 6; i < 12; i++)
         tbl[i] = '{8'(i), 8'(8'h11 + i - 6)};
      tbl[12] = '{8'd12, 8'h04};
      tbl[13] = '{8'd13, 8'h00};
      tbl[14] = '{8'd14, 8'h08};
      tbl[15] = '{8'd15, 8'h00};
      tbl[16] = '{8'd16, 8'hA0};
      tbl[17] = '{8'd17, 8'h00};
      tbl[18] = '{8'd18, 8'h00};
      tbl[19] = '{8'd19, 8'h00};
      tbl[20] = '{8'd20, 8'h01};
      tbl[21] = '{8'd21, 8'h00};
      tbl[22] = '{8'd22, 8'h00};
      tbl[23] = '{8'd23, 8'h00};
      tbl[24] = '{8'd24, 8'h00};
      tbl[25] = '{8'd25, 8'h00};
      tbl[26] = '{8'd200, 8'h00};

      reset                   = 1'b0;
      bus.writedata           = '0;
      bus.write               = 1'b0;
      bus.chipselect          = 1'b0;
      bus.address             = '0;
      bus.read                = 1'b0;
      bus.ingress_port_tdata  = '0;
      bus.ingress_port_tlast  = 1'b0;
      bus.ingress_port_tvalid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tready", bus.ingress_port_tready, 0);
      chk("rst_readdata", bus.readdata, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("tready_after_rst", bus.ingress_port_tready, 1);

      // good frame, then the register table
      hdr(16'd4, 16'h0800);
      pushb(16'h2010, 1'b0);
      pushb(16'h4030, 1'b1);
      send_q(0);
      chk("commit_tready_low", bus.ingress_port_tready, 0);
      @(negedge clk);
      chk("commit_tready_high", bus.ingress_port_tready, 1);
      for (int i = 0; i < 27; i++)
         chk_rd("good_reg", tbl[i].a, tbl[i].e);

      // bad preamble at k=1 on a 10-beat frame
      q.delete();
      pushb(16'hAAAA, 1'b0);
      pushb(16'hAAAC, 1'b0);
      for (int i = 0; i < 8; i++)
         pushb(16'h1234 + 16'(i), i == 7);
      send_q(0);
      @(negedge clk);
      chk_rd("pre_status", 8'd24, 8'h01);
      chk_rd("pre_errcnt", 8'd22, 8'(ERR_EN));
      chk_rd("pre_hdr", 8'd0, 8'h01);
      chk_rd("pre_csum", 8'd16, 8'hA0);
      chk_rd("pre_good", 8'd20, 8'h01);

      // zero-length frame right after
      hdr(16'd0, 16'h0800);
      q[q.size() - 1].l = 1'b1;
      send_q(0);
      @(negedge clk);
      chk_rd("zero_csum", 8'd16, 8'h00);
      chk_rd("zero_good", 8'd20, 8'h02);
      chk_rd("zero_len", 8'd12, 8'h00);

      wr(8'd25, 8'h5A);
      wr(8'd24, 8'h01);
      chk_rd("clr_status", 8'd24, 8'h00);
      chk_rd("clr_good", 8'd20, 8'h00);
      chk_rd("clr_errcnt", 8'd22, 8'h00);

      // len 6, tlast on payload beat 2
      hdr(16'd6, 16'h0800);
      pushb(16'h0101, 1'b0);
      pushb(16'h0202, 1'b1);
      send_q(0);
      @(negedge clk);
      chk_rd("early_status", 8'd24, 8'h02);

      // len 2, no tlast on final beat, drained
      hdr(16'd2, 16'h0800);
      pushb(16'h0505, 1'b0);
      pushb(16'h1234, 1'b0);
      pushb(16'h5678, 1'b0);
      pushb(16'h9ABC, 1'b1);
      send_q(0);
      @(negedge clk);
      chk_rd("drain_errcnt", 8'd22, 8'(2 * ERR_EN));
      chk_rd("drain_good", 8'd20, 8'h00);

      // odd length
      hdr(16'd3, 16'h0800);
      pushb(16'h0201, 1'b0);
      pushb(16'hFF03, 1'b1);
      send_q(0);
      @(negedge clk);
      chk_rd("odd_csum0", 8'd16, 8'h06);
      chk_rd("odd_csum1", 8'd17, 8'h00);
      chk_rd("odd_good", 8'd20, 8'h01);
      chk_rd("odd_len", 8'd12, 8'h03);
      chk_rd("odd_src", 8'd11, 8'h16);

      // bad SFD with tlast on it, then W1C
      q.delete();
      for (int i = 0; i < 4; i++)
         pushb(16'hAAAA, i == 3);
      send_q(0);
      @(negedge clk);
      chk_rd("both_status", 8'd24, 8'h03);
      chk_rd("sfd_errcnt", 8'd22, 8'(3 * ERR_EN));
      wr(8'd24, 8'h01);
      chk_rd("w1c_pre", 8'd24, 8'h02);
      wr(8'd24, 8'h02);
      chk_rd("w1c_len", 8'd24, 8'h00);

      // clear in the COMMIT cycle
      hdr(16'd4, 16'h0800);
      pushb(16'h2010, 1'b0);
      pushb(16'h4030, 1'b1);
      send_q(0);
      wr(8'd25, 8'h00);
      @(negedge clk);
      chk_rd("race_good", 8'd20, 8'h00);
      chk_rd("race_csum", 8'd16, 8'h00);
      chk_rd("race_errcnt", 8'd22, 8'h00);

      // reset at k=7 with gaps
      hdr(16'd4, 16'h0800);
      pushb(16'h2010, 1'b0);
      pushb(16'h4030, 1'b1);
      for (int i = 0; i < 7; i++) begin
         send(q[i].d, q[i].l);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.ingress_port_tvalid = 1'b1;
      bus.ingress_port_tdata  = q[7].d;
      reset                   = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_tready", bus.ingress_port_tready, 0);
      bus.ingress_port_tvalid = 1'b0;
      reset                   = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 25; a++)
         chk_rd("midrst_reg", 8'(a), 8'h00);
      send_q(2);
      @(negedge clk);
      chk_rd("gap_good", 8'd20, 8'h01);
      chk_rd("gap_csum", 8'd16, 8'hA0);
      chk_rd("gap_status", 8'd24, 8'h00);
      chk_rd("gap_dst", 8'd0, 8'h01);
      chk_rd("gap_type", 8'd14, 8'h08);

      // length just over the limit
      hdr(16'd1501, 16'h0800);
      pushb(16'h0101, 1'b0);
      pushb(16'h0101, 1'b1);
      send_q(0);
      @(negedge clk);
      chk_rd("big_status", 8'd24, 8'h02);
      chk_rd("big_good", 8'd20, 8'h01);
      chk_rd("big_errcnt", 8'd22, 8'(ERR_EN));

      // length exactly at the limit
      hdr(16'd1500, 16'h0800);
      for (int i = 0; i < 750; i++)
         pushb(16'h0101, i == 749);
      send_q(0);
      @(negedge clk);
      chk_rd("max_csum0", 8'd16, 8'hDC);
      chk_rd("max_csum1", 8'd17, 8'h05);
      chk_rd("max_good", 8'd20, 8'h02);
      chk_rd("max_len0", 8'd12, 8'hDC);
      chk_rd("max_len1", 8'd13, 8'h05);
      chk_rd("max_errcnt_hi", 8'd23, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end
endmodule
